// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: FSM encoding,
// sampling offsets, prescale limits and the latched per-frame config.
package uart_rx_cfg_pkg;

   localparam int unsigned PRESCALE_W   = 6;
   localparam int unsigned MIN_PRESCALE = 8;
   localparam int unsigned SAMPLE_PRE   = 1;   // first sample at P/2-1
   localparam int unsigned SAMPLE_POST  = 1;   // last sample at P/2+1
   localparam int unsigned VOTE_OFS     = 2;   // majority registered at P/2+2

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   typedef struct packed {
      logic [PRESCALE_W-1:0] prescale;
      logic                  par_en;
      logic                  par_typ;
      logic                  stop2;
   } rx_cfg_t;

   // Small ratios cannot fit three samples plus the vote; clamp and force even.
   function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] raw);
      if (raw < PRESCALE_W'(MIN_PRESCALE)) return PRESCALE_W'(MIN_PRESCALE);
      return {raw[PRESCALE_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler
   import uart_rx_cfg_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic                  rx,
   input  logic [PRESCALE_W-1:0] p,
   output logic                  bit_end_c,
   output logic                  vote_valid,
   output logic                  vote_bit
);

   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] half;
   logic [2:0]            samp_q;
   logic                  maj_c;

   always_comb begin
      half      = p >> 1;
      bit_end_c = run && (edge_cnt == p - PRESCALE_W'(1));
      maj_c     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt   <= '0;
         samp_q     <= '1;
         vote_valid <= 1'b0;
         vote_bit   <= 1'b1;
      end else begin
         vote_valid <= 1'b0;
         if (!run || bit_end_c) edge_cnt <= '0;
         else                   edge_cnt <= edge_cnt + PRESCALE_W'(1);
         if (run) begin
            if (edge_cnt == half - PRESCALE_W'(SAMPLE_PRE))  samp_q[0] <= rx;
            if (edge_cnt == half)                            samp_q[1] <= rx;
            if (edge_cnt == half + PRESCALE_W'(SAMPLE_POST)) samp_q[2] <= rx;
            if (edge_cnt == half + PRESCALE_W'(VOTE_OFS)) begin
               vote_valid <= 1'b1;
               vote_bit   <= maj_c;
            end
         end
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, frame FSM, shift register,
// parity/stop checking and registered result pulses.
module uart_rx_cfg
   import uart_rx_cfg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP_BITS,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);

   localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   state_e                 state_q, next_state;
   rx_cfg_t                cfg_q;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [DATA_WIDTH-1:0]  shift_q;
   logic                   par_fail_q, stp_fail_q;
   logic                   bit_end_c, vote_valid, vote_bit;
   logic                   run_c, start_c, shift_en_c, par_chk_c, stop_vote_c;
   logic                   frame_done_c, last_data_c, stop_last_c, stp_now_c;

   // RX_IN is asynchronous; idle-high reset value avoids a false start.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) sync_q <= '1;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

   uart_rx_sampler u_sampler (
      .clk        (CLK),
      .rst_n      (RST),
      .run        (run_c),
      .rx         (rx_s),
      .p          (cfg_q.prescale),
      .bit_end_c  (bit_end_c),
      .vote_valid (vote_valid),
      .vote_bit   (vote_bit)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= ST_IDLE;
      else      state_q <= next_state;
   end

   // The last stop bit returns to IDLE at its vote so a following start edge resyncs.
   always_comb begin
      next_state = state_q;
      case (state_q)
         ST_IDLE:   if (!rx_s) next_state = ST_START;
         ST_START: begin
            if (vote_valid && vote_bit) next_state = ST_IDLE;
            else if (bit_end_c)         next_state = ST_DATA;
         end
         ST_DATA:   if (bit_end_c && last_data_c) next_state = cfg_q.par_en ? ST_PARITY : ST_STOP;
         ST_PARITY: if (bit_end_c) next_state = ST_STOP;
         ST_STOP:   if (vote_valid && stop_last_c) next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      run_c        = (state_q != ST_IDLE);
      start_c      = (state_q == ST_IDLE) && !rx_s;
      shift_en_c   = (state_q == ST_DATA) && vote_valid;
      par_chk_c    = (state_q == ST_PARITY) && vote_valid;
      stop_vote_c  = (state_q == ST_STOP) && vote_valid;
      last_data_c  = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
      stop_last_c  = !cfg_q.stop2 || (bit_cnt == BIT_CNT_W'(1));
      frame_done_c = stop_vote_c && stop_last_c;
      stp_now_c    = stp_fail_q || !vote_bit;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cfg_q      <= '{prescale: PRESCALE_W'(MIN_PRESCALE), par_en: 1'b0, par_typ: 1'b0, stop2: 1'b0};
         bit_cnt    <= '0;
         shift_q    <= '0;
         par_fail_q <= 1'b0;
         stp_fail_q <= 1'b0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         busy       <= (next_state != ST_IDLE);
         if (start_c) begin
            cfg_q      <= '{prescale: eff_prescale(Prescale), par_en: PAR_EN,
                            par_typ: PAR_TYP, stop2: STOP_BITS};
            bit_cnt    <= '0;
            par_fail_q <= 1'b0;
            stp_fail_q <= 1'b0;
         end
         if (shift_en_c) shift_q <= {vote_bit, shift_q[DATA_WIDTH-1:1]};
         if (state_q == ST_DATA && bit_end_c)
            bit_cnt <= last_data_c ? '0 : bit_cnt + BIT_CNT_W'(1);
         if (state_q == ST_STOP && bit_end_c) bit_cnt <= BIT_CNT_W'(1);
         if (par_chk_c && (vote_bit != (^shift_q ^ cfg_q.par_typ))) par_fail_q <= 1'b1;
         if (stop_vote_c && !vote_bit) stp_fail_q <= 1'b1;
         if (frame_done_c) begin
            par_err <= par_fail_q;
            stp_err <= stp_now_c;
            if (!par_fail_q && !stp_now_c) begin
               P_DATA     <= shift_q;
               data_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg: good frames, parity and stop
// errors, start glitch, back-to-back frames, mid-frame reset and prescale clamp.
module tb_uart_rx_cfg;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN, PAR_TYP, STOP_BITS;
   logic [7:0] P_DATA;
   logic       data_valid, par_err, stp_err, busy;

   int n_checks = 0;
   int n_pass   = 0;

   int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cyc = 0, wide_cnt = 0;
   logic       dv_prev = 1'b0, pe_prev = 1'b0, se_prev = 1'b0;
   logic [7:0] dv_data [0:63];
   int         d0, p0, s0, b0;

   uart_rx_cfg #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP_BITS  (STOP_BITS),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   // Pulse and busy bookkeeping, sampled mid-cycle.
   always @(negedge CLK) begin
      if (data_valid) begin
         dv_data[dv_cnt[5:0]] <= P_DATA;
         dv_cnt <= dv_cnt + 1;
      end
      if (par_err) pe_cnt <= pe_cnt + 1;
      if (stp_err) se_cnt <= se_cnt + 1;
      if (busy)    busy_cyc <= busy_cyc + 1;
      if ((data_valid && dv_prev) || (par_err && pe_prev) || (stp_err && se_prev))
         wide_cnt <= wide_cnt + 1;
      dv_prev <= data_valid;
      pe_prev <= par_err;
      se_prev <= stp_err;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_bit(input int p, input logic b);
      RX_IN = b;
      tick(p);
   endtask

   task automatic send_frame(input int p, input logic [7:0] d, input logic par_en,
                             input logic par_bit, input int nstop, input logic last_stop);
      send_bit(p, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(p, d[i]);
      if (par_en) send_bit(p, par_bit);
      for (int i = 0; i < nstop; i++) send_bit(p, (i == nstop - 1) ? last_stop : 1'b1);
      RX_IN = 1'b1;
   endtask

   task automatic snap();
      d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt; b0 = busy_cyc;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick(1);
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      RST = 1'b0; RX_IN = 1'b1;
      Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP_BITS = 1'b0;
      tick(3);
      check("rst_pdata", 32'(P_DATA), 32'h0);
      check("rst_dv",    32'(data_valid), 32'd0);
      check("rst_errs",  32'({par_err, stp_err}), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      RST = 1'b1;
      tick(10);

      // 1: 0xA5, even parity bit 0, P=8, one stop bit
      snap();
      send_frame(8, 8'hA5, 1'b1, 1'b0, 1, 1'b1);
      tick(8);
      check("t1_dv",    32'(dv_cnt - d0), 32'd1);
      check("t1_pdata", 32'(P_DATA), 32'hA5);
      check("t1_pe",    32'(pe_cnt - p0), 32'd0);
      check("t1_se",    32'(se_cnt - s0), 32'd0);
      check("t1_busy",  32'(busy_cyc - b0), 32'd88);

      // 2: 0x3C needs parity 0; send 1
      snap();
      send_frame(8, 8'h3C, 1'b1, 1'b1, 1, 1'b1);
      tick(8);
      check("t2_pe",    32'(pe_cnt - p0), 32'd1);
      check("t2_dv",    32'(dv_cnt - d0), 32'd0);
      check("t2_se",    32'(se_cnt - s0), 32'd0);
      check("t2_pdata", 32'(P_DATA), 32'hA5);

      // 3: P=16, no parity, two stop bits, second stop low
      Prescale = 6'd16; PAR_EN = 1'b0; STOP_BITS = 1'b1;
      snap();
      send_frame(16, 8'h55, 1'b0, 1'b0, 2, 1'b0);
      tick(48);
      wait_idle("t3_idle", 200);
      check("t3_se",    32'(se_cnt - s0), 32'd1);
      check("t3_dv",    32'(dv_cnt - d0), 32'd0);
      check("t3_pe",    32'(pe_cnt - p0), 32'd0);
      check("t3_pdata", 32'(P_DATA), 32'hA5);
      snap();
      send_frame(16, 8'h0F, 1'b0, 1'b0, 2, 1'b1);
      tick(16);
      check("t3b_dv",    32'(dv_cnt - d0), 32'd1);
      check("t3b_pdata", 32'(P_DATA), 32'h0F);
      check("t3b_errs",  32'((pe_cnt - p0) + (se_cnt - s0)), 32'd0);

      // 4: 3-cycle low glitch, then 0x81
      STOP_BITS = 1'b0;
      snap();
      send_bit(3, 1'b0);
      RX_IN = 1'b1;
      tick(40);
      check("t4_busy_cyc", 32'(busy_cyc - b0), 32'd12);
      check("t4_busy",     32'(busy), 32'd0);
      check("t4_pulses",   32'((dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0)), 32'd0);
      snap();
      send_frame(16, 8'h81, 1'b0, 1'b0, 1, 1'b1);
      tick(16);
      check("t4b_dv",    32'(dv_cnt - d0), 32'd1);
      check("t4b_pdata", 32'(P_DATA), 32'h81);

      // 5: back-to-back 0x12, 0x34 at P=32
      Prescale = 6'd32;
      snap();
      send_frame(32, 8'h12, 1'b0, 1'b0, 1, 1'b1);
      send_frame(32, 8'h34, 1'b0, 1'b0, 1, 1'b1);
      tick(32);
      check("t5_dv",    32'(dv_cnt - d0), 32'd2);
      check("t5_first", 32'(dv_data[6'(d0)]), 32'h12);
      check("t5_second", 32'(dv_data[6'(d0 + 1)]), 32'h34);
      check("t5_errs",  32'((pe_cnt - p0) + (se_cnt - s0)), 32'd0);
      check("t5_pdata", 32'(P_DATA), 32'h34);

      // 6: reset in the middle of the data bits of 0xFF; Prescale=5 acts as 8
      Prescale = 6'd5;
      send_bit(8, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(8, 1'b1);
      check("t6_busy_pre", 32'(busy), 32'd1);
      RST = 1'b0;
      #1;
      check("t6_rst_pdata", 32'(P_DATA), 32'h0);
      check("t6_rst_busy",  32'(busy), 32'd0);
      check("t6_rst_dv",    32'(data_valid), 32'd0);
      tick(4);
      RST = 1'b1;
      snap();
      tick(100);
      check("t6_no_pulse", 32'((dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0)), 32'd0);
      snap();
      send_frame(8, 8'h5A, 1'b0, 1'b0, 1, 1'b1);
      tick(8);
      check("t6_dv",    32'(dv_cnt - d0), 32'd1);
      check("t6_pdata", 32'(P_DATA), 32'h5A);
      check("t6_errs",  32'((pe_cnt - p0) + (se_cnt - s0)), 32'd0);

      check("pulse_width", 32'(wide_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Single-clock, parametrised UART receiver. Successor to the fixed 8N1-style receiver in the UART subsystem.
- Adds:
  - input synchroniser
  - 3-sample majority vote
  - runtime-selectable 1/2 stop bits
  - parity and stop-bit error reporting
  - start-glitch rejection
  - busy status
- Sits between the RX pad and the RX-side data synchroniser / system controller. Runs on the oversampling clock.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (5..9 legal).
- SYNC_STAGES, 2, flops in RX_IN synchroniser (>=2).

Ports:
- CLK  input  1  oversampling clock (Prescale x baud)
- RST  input  1  asynchronous active-low reset
- RX_IN  input  1  serial line, idle high, asynchronous to CLK
- Prescale  input  6  oversampling ratio per bit
- PAR_EN  input  1  1 = parity bit present
- PAR_TYP  input  1  0 = even, 1 = odd
- STOP_BITS  input  1  0 = one stop bit, 1 = two
- P_DATA  output  DATA_WIDTH  last good received word
- data_valid  output  1  one-cycle pulse: P_DATA updated
- par_err  output  1  one-cycle pulse: parity mismatch
- stp_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high while FSM not IDLE

Behaviour:
- Reset (RST low, asynchronous):
  - FSM = IDLE; all counters 0.
  - Synchroniser flops set to 1.
  - P_DATA = 0; data_valid = par_err = stp_err = busy = 0.
- Synchroniser: rx_s = RX_IN delayed SYNC_STAGES cycles. All logic below uses rx_s only.
- Config latch:
  - Prescale, PAR_EN, PAR_TYP and STOP_BITS are captured in the cycle the FSM leaves IDLE.
  - They are held for the whole frame; changes mid-frame are ignored.
- Prescale clamping: effective P = max(Prescale, 8) with bit0 forced to 0 (even). Values 0..7 behave as 8.
- Counters:
  - edge_cnt runs 0..P-1 within each bit and wraps to 0.
  - bit_cnt counts data bits 0..DATA_WIDTH-1 and stop bits 0..1.
- Sampling:
  - rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The majority value is registered at edge_cnt = P/2+2; all decisions use that value.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s == 0 -> START, edge_cnt = 0, busy = 1 next cycle.
  - START: at the vote, value 1 -> IDLE (glitch; no outputs). Value 0 continues; at edge_cnt = P-1 -> DATA.
  - DATA: voted bit is shifted into the shift register LSB-first. After bit DATA_WIDTH-1 at edge_cnt = P-1: go to PARITY if PAR_EN, else STOP.
  - PARITY: computed parity = XOR of data bits XOR PAR_TYP. A mismatch with the voted bit sets a par_fail flag. At edge_cnt = P-1 -> STOP.
  - STOP: a voted 0 sets a stp_fail flag. For the last stop bit (first if STOP_BITS = 0, second if 1), the FSM goes to IDLE at the vote cycle itself, not at the bit end. This allows the next start edge in the second half of the stop bit to be caught (resync). For the first of two stop bits, go on to the second at edge_cnt = P-1.
- Outputs, in the cycle after the final stop vote:
  - No failure flag set: P_DATA <= shift register, data_valid = 1.
  - Any flag set: P_DATA keeps its old value, data_valid = 0. par_err and/or stp_err pulse per flag; both may pulse together.
  - All pulses last exactly 1 cycle.
  - busy falls on the same edge.
- Line held low (break): stp_err pulses, then IDLE immediately sees rx_s = 0 and starts a new frame. This is required behaviour.
- Reset mid-frame: immediate abort to reset values. No pulses are generated for the partial frame.
- Frame latency: from the RX_IN falling edge to data_valid = SYNC_STAGES + 1 + P·(1 + DATA_WIDTH + PAR_EN + STOP_BITS) + P/2 + 3 cycles (±1 for input phase).

Decomposition:
- Shared uart package:
  - FSM state encoding (3-bit enum)
  - sample offsets (P/2-1, P/2, P/2+1, vote at P/2+2)
  - min prescale constant 8
- One natural sub-module, uart_rx_sampler:
  - contains edge_cnt and the 3-sample majority vote
  - outputs vote_valid and vote_bit
- FSM, shift register, parity check and output registers stay in the top.

Test Plan:
1. Prescale=8, PAR_EN=1, PAR_TYP=0, STOP_BITS=0, send 0xA5 with parity 0 -> P_DATA=0xA5, one data_valid pulse, par_err=stp_err=0, busy high ~11·8 cycles.
2. Same config, send 0x3C with parity bit 1 -> par_err pulses once, data_valid stays 0, P_DATA keeps 0xA5.
3. Prescale=16, PAR_EN=0, STOP_BITS=1, send 0x55 with second stop bit driven 0 -> stp_err pulses once, no data_valid. Then a good 0x0F frame -> P_DATA=0x0F.
4. Low glitch of 3 cycles at Prescale=16 -> FSM returns to IDLE after the START vote, no pulses. The following 0x81 frame is received correctly.
5. Back-to-back frames 0x12, 0x34 at Prescale=32, 1 stop bit, no idle gap -> two data_valid pulses, P_DATA 0x12 then 0x34, no errors.
6. Assert RST low mid-DATA of frame 0xFF -> all outputs 0 immediately. After release, no pulse; the next 0x5A frame is received correctly. Prescale=5 in the same run behaves as 8.
